shift_left_2: RTL and testbench

// - Word-aligns the sign-extended immediate: out = in << SHIFT (default 2), i.e. x4.
// - Feeds the branch-target adder in the MIPS datapath (PC+4 + offset*4).
// - One registered stage with a valid qualifier and a sign-overflow flag.
//

---
 rtl/shift_left_2_pkg.sv | 9 +
 rtl/shift_left_2_if.sv | 29 ++
 rtl/shift_left_2.sv | 62 ++++++
 tb/tb_shift_left_2.sv | 123 ++++++++++++
 4 files changed

// File: rtl/shift_left_2_pkg.sv
// Shared constants and types for the immediate word-alignment stage.
package shift_left_2_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int IMM_SHIFT  = 2;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage : shift_left_2_pkg

// File: rtl/shift_left_2_if.sv
// Bundle of the immediate input and the registered shifted output.
// The master drives the immediate and the slave (the shifter) returns the result.
interface shift_left_2_if #(
    parameter int WIDTH = shift_left_2_pkg::DATA_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] SignImm;
    logic [WIDTH-1:0] SignImmShifted;
    logic             out_valid;
    logic             overflow;

    modport master (
        output in_valid,
        output SignImm,
        input  SignImmShifted,
        input  out_valid,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  SignImm,
        output SignImmShifted,
        output out_valid,
        output overflow
    );

endinterface : shift_left_2_if

// File: rtl/shift_left_2.sv
// Word-aligns a sign-extended immediate (x 2^SHIFT) with one register stage,
// a valid qualifier, and a flag for lost significant bits.
module shift_left_2
    import shift_left_2_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int SHIFT = IMM_SHIFT
) (
    input  logic          clk,
    input  logic          reset,
    shift_left_2_if.slave bus
);

    logic [WIDTH-1:0] shifted;
    logic             ovf;
    logic [SHIFT:0]   top_bits;

    logic [WIDTH-1:0] data_reg;
    logic             ovf_reg;
    logic             valid_reg;

    // Bit-level wiring of the constant shift; low SHIFT bits are tied to zero.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (gi < SHIFT) begin : g_zero
            assign shifted[gi] = 1'b0;
        end else begin : g_move
            assign shifted[gi] = bus.SignImm[gi-SHIFT];
        end
    end

    // The top SHIFT+1 bits must all equal the sign bit for the scaled value to fit.
    // With SHIFT=0 this slice is a single bit, so the flag is always clear.
    assign top_bits = bus.SignImm[WIDTH-1 -: SHIFT+1];

    // Overflow detection: anything other than all-zeros or all-ones in the top slice.
    always_comb begin
        ovf = 1'b0;
        if ((top_bits != '0) && (top_bits != '1)) begin
            ovf = 1'b1;
        end
    end

    // Output register: reset clears everything, idle cycles hold data and flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg  <= '0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else if (bus.in_valid) begin
            data_reg  <= shifted;
            ovf_reg   <= ovf;
            valid_reg <= 1'b1;
        end else begin
            valid_reg <= 1'b0;
        end
    end

    assign bus.SignImmShifted = data_reg;
    assign bus.overflow       = ovf_reg;
    assign bus.out_valid      = valid_reg;

endmodule : shift_left_2

// File: tb/tb_shift_left_2.sv
// Directed bench for shift_left_2: default x4 instance plus a SHIFT=0 instance
// driven with the same stimulus.
module tb_shift_left_2;

    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    shift_left_2_if #(.WIDTH(32)) bus4 ();
    shift_left_2_if #(.WIDTH(32)) bus0 ();

    shift_left_2 #(.WIDTH(32), .SHIFT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    shift_left_2 #(.WIDTH(32), .SHIFT(0)) dut_s0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic vld, input logic [31:0] imm);
        reset         = rst;
        bus4.in_valid = vld;
        bus4.SignImm  = imm;
        bus0.in_valid = vld;
        bus0.SignImm  = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp_data,
                             input logic exp_valid, input logic exp_ovf);
        $display("txn %s: data=%08h valid=%0b ovf=%0b", tag,
                 bus4.SignImmShifted, bus4.out_valid, bus4.overflow);
        check({tag, ".data"},  bus4.SignImmShifted, exp_data);
        check({tag, ".valid"}, {31'b0, bus4.out_valid}, {31'b0, exp_valid});
        check({tag, ".ovf"},   {31'b0, bus4.overflow}, {31'b0, exp_ovf});
    endtask

    initial begin
        // Reset held for two cycles
        drive(1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        check_out("reset", 32'h0000_0000, 1'b0, 1'b0);

        // Directed vectors, back to back
        drive(1'b0, 1'b1, 32'h0000_0000);
        check_out("zero", 32'h0000_0000, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_0004);
        check_out("four", 32'h0000_0010, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_000F);
        check_out("x0f", 32'h0000_003C, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'hFFFF_FFF0);
        check_out("neg", 32'hFFFF_FFC0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h1234_5678);
        check_out("mixed", 32'h48D1_59E0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h4000_0000);
        check_out("ovf_pos", 32'h0000_0000, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 32'h9FFF_FFFF);
        check_out("ovf_neg", 32'h7FFF_FFFC, 1'b1, 1'b1);

        // Idle: data and flag hold, input changes are ignored
        drive(1'b0, 1'b0, 32'h0000_0001);
        check_out("idle1", 32'h7FFF_FFFC, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'hFFFF_FFFF);
        check_out("idle2", 32'h7FFF_FFFC, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h4000_0000);
        check_out("idle3", 32'h7FFF_FFFC, 1'b0, 1'b1);

        // Boundary: largest positive value that still fits, then smallest negative
        drive(1'b0, 1'b1, 32'h1FFF_FFFF);
        check_out("max_fit", 32'h7FFF_FFFC, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'hE000_0000);
        check_out("min_fit", 32'h8000_0000, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h2000_0000);
        check_out("ovf_edge", 32'h8000_0000, 1'b1, 1'b1);

        // Reset the cycle after a valid input drops the result
        drive(1'b0, 1'b1, 32'h0000_0004);
        check_out("pre_rst", 32'h0000_0010, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0000);
        check_out("mid_rst", 32'h0000_0000, 1'b0, 1'b0);

        // Reset wins over a simultaneous valid input
        drive(1'b0, 1'b1, 32'h6000_0000);
        check_out("pre_rst2", 32'h8000_0000, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 32'h0000_0004);
        check_out("rst_wins", 32'h0000_0000, 1'b0, 1'b0);

        // SHIFT=0 instance is a plain register with no overflow
        drive(1'b0, 1'b1, 32'h9FFF_FFFF);
        check("s0.data", bus0.SignImmShifted, 32'h9FFF_FFFF);
        check("s0.ovf", {31'b0, bus0.overflow}, 32'h0);
        check("s0.valid", {31'b0, bus0.out_valid}, 32'h1);
        drive(1'b0, 1'b1, 32'h4000_0000);
        check("s0.data2", bus0.SignImmShifted, 32'h4000_0000);
        check("s0.ovf2", {31'b0, bus0.overflow}, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        check("s0.hold", bus0.SignImmShifted, 32'h4000_0000);
        check("s0.idle", {31'b0, bus0.out_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_left_2
